// File: rtl/posit_defines_p.sv
// Shared posit definitions: derived field widths, NaR encoding and the
// decoded-value layout used by the decode, add, multiply and accumulate paths.
package posit_defines_p;

   // Fraction width once sign, the shortest regime (2 bits) and ES are removed.
   function automatic int fbits_f(input int nbits, input int es);
      return nbits - 3 - es;
   endfunction

   // Signed scale width: covers +/-(nbits-2)*2^es plus the exponent.
   function automatic int sbits_f(input int nbits, input int es);
      return $clog2((nbits - 2) << es) + 1;
   endfunction

   // NaR is a one followed by nbits-1 zeros.
   function automatic logic [63:0] nar_f(input int nbits);
      return 64'd1 << (nbits - 1);
   endfunction

   localparam int FBITS32 = fbits_f(32, 2);
   localparam int SBITS32 = sbits_f(32, 2);

   // Decoded value for the standard 32-bit, ES=2 format. Other widths build the
   // same layout locally from fbits_f/sbits_f.
   typedef struct packed {
      logic                      sgn;
      logic signed [SBITS32-1:0] scale;
      logic [FBITS32-1:0]        fraction;
      logic                      inf;
      logic                      zero;
   } posit32_value_t;

endpackage

// File: rtl/posit_lzc.sv
// Leading-run counter: length of the run of bits equal to the MSB, and a flag
// when the whole word is one run.
module posit_lzc #(
   parameter int W  = 31,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] count,
   output logic          all_same
);

   logic found;

   // Scan downward from just below the MSB; the first differing bit ends the run.
   always_comb begin
      count    = CW'(W);
      all_same = 1'b1;
      found    = 1'b0;
      for (int i = W - 2; i >= 0; i--) begin
         if (!found && (bits[i] != bits[W-1])) begin
            count    = CW'(W - 1 - i);
            all_same = 1'b0;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/posit_extract_pipe.sv
// Three-stage posit decoder with valid/ready on both sides and a tag that
// travels with each operand: S1 classifies, S2 decodes the regime, S3 splits
// exponent and fraction and forms the scale.
module posit_extract_pipe
   import posit_defines_p::*;
#(
   parameter int NBITS = 32,
   parameter int ES    = 2,
   parameter int TAG_W = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NBITS-1:0]                in_posit,
   input  logic [TAG_W-1:0]                in_tag,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_sgn,
   output logic [sbits_f(NBITS, ES)-1:0]   out_scale,
   output logic [fbits_f(NBITS, ES)-1:0]   out_fraction,
   output logic                            out_inf,
   output logic                            out_zero,
   output logic [TAG_W-1:0]                out_tag
);

   localparam int FBITS = fbits_f(NBITS, ES);
   localparam int SBITS = sbits_f(NBITS, ES);
   localparam int BW    = NBITS - 1;          // body width (sign removed)
   localparam int MW    = $clog2(BW + 1);     // run length width
   localparam int KW    = MW + 1;             // signed regime value width
   localparam int RW    = NBITS - 3;          // exponent + fraction bits kept after the regime
   localparam int EW    = (ES > 0) ? ES : 1;
   localparam logic [NBITS-1:0] NAR = NBITS'(nar_f(NBITS));

   typedef struct packed {
      logic             sgn;
      logic [SBITS-1:0] scale;
      logic [FBITS-1:0] fraction;
      logic             inf;
      logic             zero;
   } value_t;

   // Stage registers
   logic                 s1_valid_reg, s1_sgn_reg, s1_zero_reg, s1_inf_reg;
   logic [BW-1:0]        s1_body_reg;
   logic [TAG_W-1:0]     s1_tag_reg;

   logic                 s2_valid_reg, s2_sgn_reg, s2_zero_reg, s2_inf_reg;
   logic signed [KW-1:0] s2_k_reg;
   logic [RW-1:0]        s2_rest_reg;
   logic [TAG_W-1:0]     s2_tag_reg;

   logic                 s3_valid_reg;
   value_t               s3_val_reg;
   logic [TAG_W-1:0]     s3_tag_reg;

   // Stage advance controls, chained back from the output
   logic s1_load, s2_load, s3_load;

   assign s3_load  = !s3_valid_reg | out_ready;
   assign s2_load  = !s2_valid_reg | s3_load;
   assign s1_load  = !s1_valid_reg | s2_load;
   assign in_ready = s1_load;

   // S1 combinational: magnitude body with the sign bit dropped
   logic [BW-1:0] body_next;
   assign body_next = BW'(in_posit[NBITS-1] ? (~in_posit + 1'b1) : in_posit);

   // S2 combinational: regime run length, k, and the bits after the terminator
   logic [MW-1:0]        run_len;
   logic                 run_all;
   logic [KW-1:0]        shamt;
   logic signed [KW-1:0] k_next;
   logic [RW-1:0]        rest_next;

   posit_lzc #(.W(BW), .CW(MW)) u_lzc (
      .bits     (s1_body_reg),
      .count    (run_len),
      .all_same (run_all)
   );

   assign shamt     = {1'b0, run_len} + KW'(1);
   assign k_next    = s1_body_reg[BW-1] ? (KW'(run_len) - KW'(1)) : (KW'(0) - KW'(run_len));
   // Shifting by run+1 drops the run and terminator; the low two bits are
   // always vacated, so only RW bits are carried forward.
   assign rest_next = run_all ? '0 : RW'((s1_body_reg << shamt) >> 2);

   // S3 combinational: exponent, fraction, scale and special-value forcing
   logic [EW-1:0] e_val;
   value_t        s3_val_next;

   if (ES > 0) begin : g_exp
      assign e_val = s2_rest_reg[RW-1 -: EW];
   end else begin : g_no_exp
      assign e_val = '0;
   end

   // Zero and NaR carry no magnitude, so their fields are cleared.
   always_comb begin
      s3_val_next          = '0;
      s3_val_next.inf      = s2_inf_reg;
      s3_val_next.zero     = s2_zero_reg;
      if (!(s2_zero_reg | s2_inf_reg)) begin
         s3_val_next.sgn      = s2_sgn_reg;
         s3_val_next.scale    = SBITS'((32'(s2_k_reg) <<< ES) + 32'(e_val));
         s3_val_next.fraction = s2_rest_reg[FBITS-1:0];
      end
   end

   // S1 register: capture and classify the accepted operand
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_reg <= 1'b0;
         s1_sgn_reg   <= 1'b0;
         s1_zero_reg  <= 1'b0;
         s1_inf_reg   <= 1'b0;
         s1_body_reg  <= '0;
         s1_tag_reg   <= '0;
      end else if (s1_load) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_sgn_reg  <= in_posit[NBITS-1];
            s1_zero_reg <= (in_posit == '0);
            s1_inf_reg  <= (in_posit == NAR);
            s1_body_reg <= body_next;
            s1_tag_reg  <= in_tag;
         end
      end
   end

   // S2 register: regime value and remaining bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid_reg <= 1'b0;
         s2_sgn_reg   <= 1'b0;
         s2_zero_reg  <= 1'b0;
         s2_inf_reg   <= 1'b0;
         s2_k_reg     <= '0;
         s2_rest_reg  <= '0;
         s2_tag_reg   <= '0;
      end else if (s2_load) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_sgn_reg  <= s1_sgn_reg;
            s2_zero_reg <= s1_zero_reg;
            s2_inf_reg  <= s1_inf_reg;
            s2_k_reg    <= k_next;
            s2_rest_reg <= rest_next;
            s2_tag_reg  <= s1_tag_reg;
         end
      end
   end

   // S3 register: final decoded value, held while the consumer stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s3_valid_reg <= 1'b0;
         s3_val_reg   <= '0;
         s3_tag_reg   <= '0;
      end else if (s3_load) begin
         s3_valid_reg <= s2_valid_reg;
         if (s2_valid_reg) begin
            s3_val_reg <= s3_val_next;
            s3_tag_reg <= s2_tag_reg;
         end
      end
   end

   assign out_valid    = s3_valid_reg;
   assign out_sgn      = s3_val_reg.sgn;
   assign out_scale    = s3_val_reg.scale;
   assign out_fraction = s3_val_reg.fraction;
   assign out_inf      = s3_val_reg.inf;
   assign out_zero     = s3_val_reg.zero;
   assign out_tag      = s3_tag_reg;

endmodule

// File: tb/tb_posit_extract_pipe.sv
// Bench for posit_extract_pipe: 32/2 and 16/1 instances checked against a
// value-level posit decoding model.
`timescale 1ns/1ps
module tb_posit_extract_pipe;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 32-bit, ES=2 instance
   logic              in_valid, in_ready, out_valid, out_ready;
   logic [31:0]       in_posit;
   logic [7:0]        in_tag, out_tag;
   logic              out_sgn, out_inf, out_zero;
   logic signed [7:0] out_scale;
   logic [26:0]       out_fraction;

   // 16-bit, ES=1 instance
   logic              h_in_valid, h_in_ready, h_out_valid, h_out_ready;
   logic [15:0]       h_in_posit;
   logic [7:0]        h_in_tag, h_out_tag;
   logic              h_out_sgn, h_out_inf, h_out_zero;
   logic signed [5:0] h_out_scale;
   logic [11:0]       h_out_fraction;

   int errors = 0;
   int checks = 0;

   posit_extract_pipe #(.NBITS(32), .ES(2), .TAG_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_sgn(out_sgn),
      .out_scale(out_scale), .out_fraction(out_fraction), .out_inf(out_inf),
      .out_zero(out_zero), .out_tag(out_tag)
   );

   posit_extract_pipe #(.NBITS(16), .ES(1), .TAG_W(8)) dut16 (
      .clk(clk), .reset(reset),
      .in_valid(h_in_valid), .in_ready(h_in_ready), .in_posit(h_in_posit), .in_tag(h_in_tag),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .out_sgn(h_out_sgn),
      .out_scale(h_out_scale), .out_fraction(h_out_fraction), .out_inf(h_out_inf),
      .out_zero(h_out_zero), .out_tag(h_out_tag)
   );

   // Reference decode: negate to magnitude, count the regime run, then read
   // exponent and fraction from whatever bits remain.
   function automatic void model(input logic [31:0] p, input int n, input int es,
                                 output logic sgn, output int scale, output logic [63:0] frac,
                                 output logic inf, output logic zero);
      logic [63:0] x, rv;
      int run, rem, fr, k, e, fb;
      logic r;
      fb = n - 3 - es;
      sgn = 0; scale = 0; frac = 0; inf = 0; zero = 0;
      if (p == 0) begin zero = 1; return; end
      if (64'(p) == (64'd1 << (n - 1))) begin inf = 1; return; end
      sgn = p[n-1];
      x = sgn ? ((64'd1 << n) - 64'(p)) : 64'(p);
      r = x[n-2];
      run = 0;
      while (run < n - 1 && x[n-2-run] == r) run++;
      k = r ? run - 1 : -run;
      rem = n - 2 - run;
      if (rem < 0) rem = 0;
      rv = x & ((64'd1 << rem) - 1);
      if (rem >= es) begin
         e = int'(rv >> (rem - es));
         fr = rem - es;
         frac = (rv & ((64'd1 << fr) - 1)) << (fb - fr);
      end else begin
         e = int'(rv << (es - rem));
      end
      scale = k * (1 << es) + e;
   endfunction

   function automatic logic [31:0] rand_posit();
      logic [31:0] p;
      int sh;
      p = $urandom;
      sh = $urandom_range(0, 31);
      case ($urandom_range(0, 5))
         0: return p;
         1: return p >> sh;
         2: return ~(p >> sh);
         3: return {1'b0, p[30:0]} | (32'h7FFFFFFF >> sh << sh);
         4: return 32'h0;
         default: return 32'h80000000;
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 0; in_posit = 0; in_tag = 0; out_ready = 1;
      h_in_valid = 0; h_in_posit = 0; h_in_tag = 0; h_out_ready = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got=%b want=0", out_valid); end
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_scale !== 0 || out_fraction !== 0 ||
          out_tag !== 0 || out_sgn !== 0 || out_inf !== 0 || out_zero !== 0) begin
         errors++;
         $display("FAIL reset_state in_ready=%b out_valid=%b scale=%0d frac=%h tag=%h want 1,0,0,0,0",
                  in_ready, out_valid, out_scale, out_fraction, out_tag);
      end
      checks++;
      if (h_in_ready !== 1'b1 || h_out_valid !== 1'b0 || h_out_scale !== 0 || h_out_fraction !== 0) begin
         errors++;
         $display("FAIL reset_state16 in_ready=%b out_valid=%b scale=%0d frac=%h want 1,0,0,0",
                  h_in_ready, h_out_valid, h_out_scale, h_out_fraction);
      end
      $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
   endtask

   // Known encodings streamed back-to-back; results must appear 3 cycles later in order.
   task automatic test_directed();
      logic [31:0] dp [8] = '{32'h40000000, 32'h48000000, 32'h44000000, 32'h00000000,
                             32'h80000000, 32'hC0000000, 32'h7FFFFFFF, 32'h00000001};
      int          ds [8] = '{0, 1, 0, 0, 0, 0, 120, -120};
      logic [26:0] df [8] = '{27'h0, 27'h0, 27'h4000000, 27'h0, 27'h0, 27'h0, 27'h0, 27'h0};
      logic        dsg[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
      logic        dif[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      logic        dz [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
      int idx;
      logic exp_v;
      out_ready = 1;
      @(posedge clk); #1;
      in_valid = 1; in_posit = dp[0]; in_tag = 8'h10;
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #1;
         if (c < 8) begin in_posit = dp[c]; in_tag = 8'h10 + 8'(c); end
         else in_valid = 0;
         @(negedge clk);
         exp_v = (c >= 3 && c <= 10);
         checks++;
         if (out_valid !== exp_v) begin
            errors++; $display("FAIL directed_valid cycle=%0d got=%b want=%b", c, out_valid, exp_v);
         end
         if (exp_v) begin
            idx = c - 3;
            checks++;
            if (out_tag !== 8'h10 + 8'(idx) || out_sgn !== dsg[idx] || int'(out_scale) != ds[idx] ||
                out_fraction !== df[idx] || out_inf !== dif[idx] || out_zero !== dz[idx]) begin
               errors++;
               $display("FAIL directed_value posit=%h got tag=%h s=%b sc=%0d f=%h inf=%b z=%b want tag=%h s=%b sc=%0d f=%h inf=%b z=%b",
                        dp[idx], out_tag, out_sgn, out_scale, out_fraction, out_inf, out_zero,
                        8'h10 + 8'(idx), dsg[idx], ds[idx], df[idx], dif[idx], dz[idx]);
            end
            $display("directed: posit=%h tag=%h sgn=%b scale=%0d frac=%h inf=%b zero=%b",
                     dp[idx], out_tag, out_sgn, out_scale, out_fraction, out_inf, out_zero);
         end
      end
   endtask

   // Stream n operands through the 32-bit instance. rnd=0: out_ready pattern
   // 1,0,0 with always-valid input; rnd=1: random valid and ready.
   task automatic test_backpressure(input int n, input bit rnd);
      logic [31:0] q_posit[$];
      logic [7:0]  q_tag[$];
      int sent = 0, got = 0, occ = 0, cyc = 0;
      logic acc = 0, exp_ready, stall_prev = 0;
      logic [45:0] snap = '0, now;
      logic [31:0] p;
      logic [7:0]  t;
      logic m_sgn, m_inf, m_zero;
      int m_scale;
      logic [63:0] m_frac;
      in_valid = 0;
      while (got < n && cyc < 3000) begin
         @(posedge clk); #1;
         if (in_valid && acc) in_valid = 0;
         out_ready = rnd ? ($urandom_range(0, 2) != 0) : (cyc % 3 == 0);
         if (!in_valid && sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
            in_posit = rand_posit(); in_tag = 8'(sent); in_valid = 1; sent++;
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         exp_ready = !(occ == 3 && !out_ready);
         checks++;
         if (in_ready !== exp_ready) begin
            errors++; $display("FAIL bp_in_ready cycle=%0d occ=%0d got=%b want=%b", cyc, occ, in_ready, exp_ready);
         end
         now = {out_valid, out_sgn, out_scale, out_fraction, out_inf, out_zero, out_tag[6:0]};
         if (stall_prev) begin
            checks++;
            if (now !== snap) begin
               errors++; $display("FAIL bp_hold cycle=%0d got=%h want=%h", cyc, now, snap);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q_posit.size() == 0) begin
               errors++; $display("FAIL bp_extra tag=%h got=result want=none", out_tag);
            end else begin
               p = q_posit.pop_front(); t = q_tag.pop_front();
               model(p, 32, 2, m_sgn, m_scale, m_frac, m_inf, m_zero);
               if (out_tag !== t || out_sgn !== m_sgn || int'(out_scale) != m_scale ||
                   64'(out_fraction) !== m_frac || out_inf !== m_inf || out_zero !== m_zero) begin
                  errors++;
                  $display("FAIL bp_value posit=%h got tag=%h s=%b sc=%0d f=%h inf=%b z=%b want tag=%h s=%b sc=%0d f=%h inf=%b z=%b",
                           p, out_tag, out_sgn, out_scale, out_fraction, out_inf, out_zero,
                           t, m_sgn, m_scale, m_frac, m_inf, m_zero);
               end
               if (!rnd) $display("bp: posit=%h tag=%h scale=%0d frac=%h", p, out_tag, out_scale, out_fraction);
            end
            got++; occ--;
         end
         if (acc) begin q_posit.push_back(in_posit); q_tag.push_back(in_tag); occ++; end
         stall_prev = out_valid && !out_ready;
         snap = now;
         cyc++;
      end
      @(posedge clk); #1;
      in_valid = 0; out_ready = 1;
      checks++;
      if (got != n || q_posit.size() != 0) begin
         errors++; $display("FAIL bp_count got=%0d want=%0d pending=%0d", got, n, q_posit.size());
      end
      $display("stream: mode=%0d received=%0d of %0d in %0d cycles", rnd, got, n, cyc);
   endtask

   task automatic test_reset_midflight();
      bit seen = 0;
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1; in_posit = 32'h40000000 + 32'(i); in_tag = 8'h50 + 8'(i);
      end
      @(posedge clk); #1 in_valid = 0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL midflight_full out_valid=%b in_ready=%b want 1,0", out_valid, in_ready);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_tag !== 8'h00) begin
         errors++; $display("FAIL midflight_async out_valid=%b tag=%h want 0,00", out_valid, out_tag);
      end
      @(posedge clk); #1;
      reset = 1'b0; out_ready = 1;
      in_valid = 1; in_posit = 32'h48000000; in_tag = 8'hA5;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk); #1;
         if (c == 0) in_valid = 0;
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            checks++;
            if (out_tag !== 8'hA5 || int'(out_scale) != 1 || out_fraction !== 0) begin
               errors++; $display("FAIL midflight_first tag=%h scale=%0d frac=%h want a5,1,0",
                                  out_tag, out_scale, out_fraction);
            end
            $display("midflight: first after reset tag=%h scale=%0d", out_tag, out_scale);
         end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL midflight_timeout got=none want=tag a5"); end
   endtask

   task automatic test_param16();
      logic [15:0] q_posit[$];
      logic [7:0]  q_tag[$];
      logic [15:0] fixed [3] = '{16'h4000, 16'h7FFF, 16'h8000};
      int sent = 0, got = 0, n = 23;
      logic [15:0] p;
      logic [7:0]  t;
      logic m_sgn, m_inf, m_zero;
      int m_scale;
      logic [63:0] m_frac;
      h_out_ready = 1;
      for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
         @(posedge clk); #1;
         if (sent < n) begin
            h_in_valid = 1;
            h_in_posit = (sent < 3) ? fixed[sent] : 16'($urandom);
            h_in_tag = 8'(sent);
            sent++;
         end else h_in_valid = 0;
         @(negedge clk);
         if (h_out_valid) begin
            checks++;
            if (q_posit.size() == 0) begin
               errors++; $display("FAIL p16_extra tag=%h got=result want=none", h_out_tag);
            end else begin
               p = q_posit.pop_front(); t = q_tag.pop_front();
               model(32'(p), 16, 1, m_sgn, m_scale, m_frac, m_inf, m_zero);
               if (h_out_tag !== t || h_out_sgn !== m_sgn || int'(h_out_scale) != m_scale ||
                   64'(h_out_fraction) !== m_frac || h_out_inf !== m_inf || h_out_zero !== m_zero) begin
                  errors++;
                  $display("FAIL p16_value posit=%h got tag=%h s=%b sc=%0d f=%h inf=%b z=%b want tag=%h s=%b sc=%0d f=%h inf=%b z=%b",
                           p, h_out_tag, h_out_sgn, h_out_scale, h_out_fraction, h_out_inf, h_out_zero,
                           t, m_sgn, m_scale, m_frac, m_inf, m_zero);
               end
               if (t < 3) begin
                  checks++;
                  if ((t == 0 && (h_out_scale !== 0 || h_out_fraction !== 0 || h_out_inf !== 0)) ||
                      (t == 1 && int'(h_out_scale) != 28) ||
                      (t == 2 && h_out_inf !== 1'b1)) begin
                     errors++; $display("FAIL p16_fixed posit=%h scale=%0d frac=%h inf=%b", p,
                                        h_out_scale, h_out_fraction, h_out_inf);
                  end
                  $display("p16: posit=%h scale=%0d frac=%h inf=%b", p, h_out_scale, h_out_fraction, h_out_inf);
               end
            end
            got++;
         end
         if (h_in_valid && h_in_ready) begin q_posit.push_back(h_in_posit); q_tag.push_back(h_in_tag); end
      end
      @(posedge clk); #1 h_in_valid = 0;
      checks++;
      if (got != n) begin errors++; $display("FAIL p16_count got=%0d want=%0d", got, n); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure(10, 1'b0);
      test_backpressure(300, 1'b1);
      test_reset_midflight();
      test_param16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
